// File: rtl/mmio_pkg.sv
// Shared constants, target-select enum and segment table for the MMIO bridge.
package mmio_pkg;

    localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_DIG    = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TIMER  = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_LED    = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW     = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN    = 32'hFFFF_F078;

    typedef enum logic [2:0] {
        SEL_DRAM, SEL_DIG, SEL_TIMER, SEL_LED, SEL_SW, SEL_BTN, SEL_NONE
    } sel_t;

    // Active-low {DP,G,F,E,D,C,B,A}; index 0 sits in the low byte, DP always off.
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex_seg(input logic [3:0] v);
        return SEG_HEX[v];
    endfunction

    function automatic sel_t decode(input logic [31:0] addr);
        sel_t s;
        if (addr < PERIPH_BASE) begin
            s = SEL_DRAM;
        end else begin
            case ({addr[31:2], 2'b00})
                ADDR_DIG:   s = SEL_DIG;
                ADDR_TIMER: s = SEL_TIMER;
                ADDR_LED:   s = SEL_LED;
                ADDR_SW:    s = SEL_SW;
                ADDR_BTN:   s = SEL_BTN;
                default:    s = SEL_NONE;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Seven-segment scan engine: prescaler, digit index and registered digit/segment drive.
module seg_scan
    import mmio_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] dig,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    logic [15:0] prescale;
    logic [2:0]  idx;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            prescale <= '0;
            idx      <= '0;
            dig_en   <= 8'hFE;
            dig_seg  <= 8'hFF;
        end else begin
            if (prescale == SCAN_DIV - 16'd1) begin
                prescale <= '0;
                idx      <= idx + 3'd1;
            end else begin
                prescale <= prescale + 16'd1;
            end
            // Drive from the current idx, so the pins trail idx by one cycle.
            dig_en  <= ~(8'b1 << idx);
            dig_seg <= hex_seg(dig[{idx, 2'b00} +: 4]);
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// CPU data-bus responder: DRAM pass-through plus LED/DIG/SW/BTN peripherals.
// Define BRIDGE_TIMER_EN to add the free-running TIMER register at 0xFFFF_F020.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int          DRAM_AW     = 14,
    parameter logic [15:0] SCAN_DIV    = 16'd50000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        Bus_addr,
    input  logic               Bus_wen,
    input  logic [31:0]        Bus_wdata,
    output logic [31:0]        Bus_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_wen,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         button,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         dig_seg
);

    sel_t        sel;
    logic [31:0] dig;
    logic [31:0] timer_rd;

    logic [SYNC_STAGES-1:0][23:0] sw_pipe;
    logic [SYNC_STAGES-1:0][4:0]  btn_pipe;

    always_comb begin
        sel = decode(Bus_addr);
`ifndef BRIDGE_TIMER_EN
        if (sel == SEL_TIMER) sel = SEL_NONE;
`endif
    end

    assign dram_addr  = Bus_addr[DRAM_AW+1:2];
    assign dram_wen   = Bus_wen & (sel == SEL_DRAM);
    assign dram_wdata = Bus_wdata;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            led <= '0;
            dig <= '0;
        end else if (Bus_wen) begin
            if (sel == SEL_LED) led <= Bus_wdata[23:0];
            if (sel == SEL_DIG) dig <= Bus_wdata;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            sw_pipe  <= '0;
            btn_pipe <= '0;
        end else begin
            sw_pipe  <= {sw_pipe[SYNC_STAGES-2:0], sw};
            btn_pipe <= {btn_pipe[SYNC_STAGES-2:0], button};
        end
    end

`ifdef BRIDGE_TIMER_EN
    logic [31:0] timer;

    // A bus load wins over the increment in the same cycle.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst)                          timer <= '0;
        else if (Bus_wen && sel == SEL_TIMER) timer <= Bus_wdata;
        else                                  timer <= timer + 32'd1;
    end

    assign timer_rd = timer;
`else
    assign timer_rd = '0;
`endif

    always_comb begin
        Bus_rdata = '0;
        case (sel)
            SEL_DRAM:  Bus_rdata = dram_rdata;
            SEL_DIG:   Bus_rdata = dig;
            SEL_TIMER: Bus_rdata = timer_rd;
            SEL_LED:   Bus_rdata = {8'b0, led};
            SEL_SW:    Bus_rdata = {8'b0, sw_pipe[SYNC_STAGES-1]};
            SEL_BTN:   Bus_rdata = {27'b0, btn_pipe[SYNC_STAGES-1]};
            default:   Bus_rdata = '0;
        endcase
    end

    seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .dig     (dig),
        .dig_en  (dig_en),
        .dig_seg (dig_seg)
    );

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Bus responder for the CPU's data-side bus (Bus_addr/Bus_wen/Bus_wdata in, Bus_rdata out).
- Decodes each access to DRAM or a memory-mapped peripheral, and owns the peripheral state:
  - LED register
  - 8-digit seven-segment display register with scan engine
  - synchronised switch/button inputs
  - optional free-running timer
- Sits between the CPU and the DRAM / board I/O.

Parameters:
- DRAM_AW, 14, DRAM word-address width; dram_addr = Bus_addr[DRAM_AW+1:2].
- SCAN_DIV, 16'd50000, cpu_clk cycles per seven-segment digit slot (minimum 2).
- SYNC_STAGES, 2, flip-flop stages on sw/button inputs (minimum 2).

Ports:
- cpu_clk, input, 1, system clock; all state updates on the rising edge.
- cpu_rst, input, 1, asynchronous, active-high reset.
- Bus_addr, input, 32, byte address from the CPU.
- Bus_wen, input, 1, write strobe; one write per asserted cycle.
- Bus_wdata, input, 32, write data.
- Bus_rdata, output, 32, read data; combinational from Bus_addr and registered state.
- dram_addr, output, DRAM_AW, DRAM word address.
- dram_wen, output, 1, DRAM write enable.
- dram_wdata, output, 32, DRAM write data (= Bus_wdata).
- dram_rdata, input, 32, DRAM combinational read data.
- sw, input, 24, raw board switches (asynchronous).
- button, input, 5, raw board buttons (asynchronous).
- led, output, 24, LED drive; registered.
- dig_en, output, 8, digit enables, active-low one-hot; registered.
- dig_seg, output, 8, segments {DP,G,F,E,D,C,B,A}, active-low; registered.

Behaviour:
- Address map (word-aligned; Bus_addr[1:0] ignored for peripherals):
  - 0xFFFF_F000 DIG (R/W)
  - 0xFFFF_F020 TIMER (R/W, optional)
  - 0xFFFF_F060 LED (R/W)
  - 0xFFFF_F070 SW (RO)
  - 0xFFFF_F078 BTN (RO)
  - any address below 0xFFFF_F000 is DRAM
  - any other address at or above 0xFFFF_F000 is unmapped: reads return 0, writes are dropped.
- dram_wen = Bus_wen & DRAM hit; no other target ever sees a DRAM write.
- Register writes take effect at the clock edge where Bus_wen=1 and the address matches. A read in the next cycle returns the new value.
  - LED keeps bits [23:0]; upper bits are ignored.
- Reads:
  - SW returns {8'b0, sw_sync}; BTN returns {27'b0, btn_sync}.
  - LED returns {8'b0, led}; DIG returns the full 32 bits.
  - Synchronised inputs lag raw pins by SYNC_STAGES cycles.
  - Writes to SW or BTN are ignored.
- Seven-segment scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps. On wrap, digit index idx (3 bits) increments modulo 8, 7 wrapping to 0.
  - dig_en <= ~(8'b1 << idx).
  - dig_seg <= active-low hex decode of DIG[4*idx+3 : 4*idx]; DP is always off (bit = 1).
  - Outputs are registered, so they update one cycle after idx changes.
  - A DIG write mid-slot changes dig_seg at the next register update; the scan position is not disturbed.
- Reset (asynchronous, cpu_rst=1, may assert mid-operation):
  - led=0, DIG=0, prescaler=0, idx=0, synchronisers=0, timer=0.
  - dig_en=8'hFE, dig_seg=8'hFF (blank).
  - Any write in the reset cycle is lost. dram_wen is combinational; it is qualified by Bus_wen only, not by reset.
- Width rules: dram_addr truncates Bus_addr; DRAM addresses above the DRAM size alias.

Optional Feature:
- Macro BRIDGE_TIMER_EN.
- Defined:
  - 32-bit TIMER register at 0xFFFF_F020 increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - A write loads Bus_wdata, which is read back next cycle; counting resumes from the loaded value.
  - Write has priority over increment in the same cycle.
- Undefined: 0xFFFF_F020 is unmapped (reads 0, writes dropped); no timer flops exist.

Decomposition:
- Package mmio_pkg holds:
  - address constants: ADDR_DIG, ADDR_TIMER, ADDR_LED, ADDR_SW, ADDR_BTN, PERIPH_BASE
  - the 16-entry active-low hex-to-segment table
  - target-select enum {SEL_DRAM, SEL_DIG, SEL_TIMER, SEL_LED, SEL_SW, SEL_BTN, SEL_NONE}
- One sub-module, seg_scan: prescaler, idx, and the dig_en/dig_seg registers. It takes the 32-bit DIG value and cpu_clk/cpu_rst.

Test Plan:
- DRAM path: write Bus_addr=0x0000_0010, Bus_wdata=0xDEADBEEF, Bus_wen=1 -> dram_wen=1, dram_addr=4; same-cycle read of 0x0000_0010 returns dram_rdata; write to 0xFFFF_F060 -> dram_wen=0.
- LED: write 0xFFFF_F060=0xFF12_3456 -> led=0x123456 after the edge; read returns 0x0012_3456; assert cpu_rst mid-run -> led=0 immediately, without waiting for a clock edge.
- Switches: sw changes 0 -> 0xA5A5A5 -> read of 0xFFFF_F070 returns 0 for 2 cycles, then 0x00A5A5A5; write to SW is ignored.
- Scan (SCAN_DIV=4): write DIG=0x7654_3210 -> dig_en steps FE, FD, FB ... 7F, FE every 4 cycles; digit 0 dig_seg=0xC0 ("0"); digit 7 dig_seg=0xF8 ("7").
- Timer (BRIDGE_TIMER_EN): write 0xFFFF_F020=0xFFFF_FFFE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on consecutive cycles. Without the macro, reads return 0.
- Unmapped: read 0xFFFF_F040 -> 0; write to it changes no register and dram_wen stays 0.
